uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; frames are start, DATA_BITS LSB-first, optional parity, STOP_BITS.
// Define UART_TX_PARITY_EN to compile in the parity bit (sense set by PARITY_ODD).
module uart_tx_fifo #(
  parameter int CLK_DIV    = 434,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                          CLK,
  input  logic                          RST_n,
  input  logic                          Wr_En_Sig,
  input  logic [DATA_BITS-1:0]          Wr_Data,
  output logic                          Full_Sig,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count,
  output logic                          Overflow_Sig,
  output logic                          Tx_Busy_Sig,
  output logic                          Tx_Done_Sig,
  output logic                          Tx_Pin_Out
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0]     BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [15:0]            r_baud;
  logic [3:0]             r_bit, w_bit_nxt;
  logic [DATA_BITS-1:0]   r_data;
  logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wptr, r_rptr;
  logic [AW:0]            r_count;
  logic                   r_full, r_ovf, r_done, r_tx;
  logic                   w_tick, w_empty, w_pop, w_wr_acc, w_done, w_tx_nxt, w_data_bit;
  logic [AW:0]            w_count_nxt;

  assign w_tick      = (r_baud == BAUD_LAST);
  assign w_empty     = (r_count == '0);
  assign w_wr_acc    = Wr_En_Sig && !r_full;
  assign w_count_nxt = r_count + (AW+1)'(w_wr_acc) - (AW+1)'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
          w_bit_nxt   = '0;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt = DATA;
          w_bit_nxt   = '0;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + 4'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_tick) begin
          w_state_nxt = STOP;
          w_bit_nxt   = '0;
        end
      end
`endif
      STOP: begin
        // Leaving STOP here gives one idle-high cycle before the next queued frame.
        if (w_tick) begin
          if (r_bit == STOP_LAST) begin
            w_state_nxt = IDLE;
            w_done      = 1'b1;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + 4'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Line level is derived from the next state so Tx_Pin_Out is a plain register.
  always_comb begin
    w_data_bit = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (w_bit_nxt == 4'(i)) w_data_bit = r_data[i];
    end
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_data_bit;
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_nxt = (^r_data) ^ 1'(PARITY_ODD);
`endif
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_baud  <= (r_state == IDLE || w_tick) ? '0 : r_baud + 16'd1;
      if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
      if (w_pop)    r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_C);
      r_ovf   <= Wr_En_Sig && r_full;
      r_done  <= w_done;
      r_tx    <= w_tx_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr_acc) r_mem[r_wptr] <= Wr_Data;
    if (w_pop)    r_data        <= r_mem[r_rptr];
  end

  assign Full_Sig     = r_full;
  assign Fifo_Count   = r_count;
  assign Overflow_Sig = r_ovf;
  assign Tx_Busy_Sig  = (r_state != IDLE);
  assign Tx_Done_Sig  = r_done;
  assign Tx_Pin_Out   = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: table vectors, hand sequences and random traffic against a frame-schedule model.
module tb_uart_tx_fifo;
  localparam int A_DIV = 5, A_DB = 8, A_SB = 1, A_DEPTH = 4;
  localparam int B_DIV = 4, B_DB = 7, B_SB = 2;
  localparam int C_DIV = 434, C_DB = 8, C_SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int A_F = (1 + A_DB + PAR + A_SB) * A_DIV;
  localparam int B_F = (1 + B_DB + PAR + B_SB) * B_DIV;
  localparam int C_F = (1 + C_DB + PAR + C_SB) * C_DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       a_wr, a_full, a_ovf, a_busy, a_done, a_tx;
  logic [7:0] a_data;
  logic [2:0] a_cnt;
  logic       b_wr, b_full, b_ovf, b_busy, b_done, b_tx;
  logic [6:0] b_data;
  logic [1:0] b_cnt;
  logic       c_wr, c_full, c_ovf, c_busy, c_done, c_tx;
  logic [7:0] c_data;
  logic [3:0] c_cnt;

  uart_tx_fifo #(.CLK_DIV(A_DIV), .DATA_BITS(A_DB), .STOP_BITS(A_SB), .FIFO_DEPTH(A_DEPTH)) dut_a (
    .CLK(clk), .RST_n(rst_n), .Wr_En_Sig(a_wr), .Wr_Data(a_data), .Full_Sig(a_full),
    .Fifo_Count(a_cnt), .Overflow_Sig(a_ovf), .Tx_Busy_Sig(a_busy), .Tx_Done_Sig(a_done),
    .Tx_Pin_Out(a_tx));

  uart_tx_fifo #(.CLK_DIV(B_DIV), .DATA_BITS(B_DB), .STOP_BITS(B_SB), .FIFO_DEPTH(2)) dut_b (
    .CLK(clk), .RST_n(rst_n), .Wr_En_Sig(b_wr), .Wr_Data(b_data), .Full_Sig(b_full),
    .Fifo_Count(b_cnt), .Overflow_Sig(b_ovf), .Tx_Busy_Sig(b_busy), .Tx_Done_Sig(b_done),
    .Tx_Pin_Out(b_tx));

  uart_tx_fifo dut_c (
    .CLK(clk), .RST_n(rst_n), .Wr_En_Sig(c_wr), .Wr_Data(c_data), .Full_Sig(c_full),
    .Fifo_Count(c_cnt), .Overflow_Sig(c_ovf), .Tx_Busy_Sig(c_busy), .Tx_Done_Sig(c_done),
    .Tx_Pin_Out(c_tx));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model for dut_a: queue of accepted words plus the start edge of the current frame.
  int         t;
  logic [7:0] m_q[$];
  logic [7:0] m_word;
  int         m_s, m_free;
  bit         m_active;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    int         cnt;
    int         full;
    int         ovf;
  } vec_t;
  vec_t tv[7];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, t);
    end
  endtask

  // Line level at bit slot idx of a frame carrying w.
  function automatic int fbit(input logic [8:0] w, input int idx, input int db);
    int p;
    p = 0;
    if (idx == 0) return 0;
    if (idx <= db) return int'(w[idx-1]);
    if (PAR == 1 && idx == db + 1) begin
      for (int i = 0; i < db; i++) p = p ^ int'(w[i]);
      return p;
    end
    return 1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_active = 1'b0;
    m_free   = 0;
    m_s      = 0;
  endtask

  task automatic step(input logic wr, input logic [7:0] d);
    bit pop, ovf;
    int rel, e_busy, e_done, e_tx;
    @(negedge clk);
    a_wr   = wr;
    a_data = d;
    @(posedge clk);
    t++;
    pop = (m_q.size() > 0) && (t >= m_free);
    ovf = wr && (m_q.size() == A_DEPTH);
    if (pop) begin
      m_word   = m_q.pop_front();
      m_s      = t;
      m_free   = t + A_F + 1;
      m_active = 1'b1;
    end
    if (wr && !ovf) m_q.push_back(d);
    #1;
    rel    = t - m_s;
    e_busy = (m_active && rel < A_F) ? 1 : 0;
    e_done = (m_active && rel == A_F) ? 1 : 0;
    e_tx   = e_busy ? fbit({1'b0, m_word}, rel / A_DIV, A_DB) : 1;
    chk("a_tx",    int'(a_tx),   e_tx);
    chk("a_busy",  int'(a_busy), e_busy);
    chk("a_done",  int'(a_done), e_done);
    chk("a_count", int'(a_cnt),  m_q.size());
    chk("a_full",  int'(a_full), (m_q.size() == A_DEPTH) ? 1 : 0);
    chk("a_ovf",   int'(a_ovf),  ovf ? 1 : 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn, lows, k;
    int pct[3];
    rst_n = 1'b0;
    a_wr = 1'b0; a_data = '0;
    b_wr = 1'b0; b_data = '0;
    c_wr = 1'b0; c_data = '0;
    t = 0; m_word = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx",    int'(a_tx),   1);
    chk("rst_full",  int'(a_full), 0);
    chk("rst_count", int'(a_cnt),  0);
    chk("rst_ovf",   int'(a_ovf),  0);
    chk("rst_busy",  int'(a_busy), 0);
    chk("rst_done",  int'(a_done), 0);
    chk("rst_b_tx",  int'(b_tx),   1);
    chk("rst_c_tx",  int'(c_tx),   1);
    @(negedge clk);
    rst_n = 1'b1;

    // Six back-to-back writes into a depth-4 FIFO: fifth fills it, sixth overflows.
    tv[0] = '{1'b1, 8'h11, 1, 0, 0};
    tv[1] = '{1'b1, 8'h22, 1, 0, 0};
    tv[2] = '{1'b1, 8'h33, 2, 0, 0};
    tv[3] = '{1'b1, 8'h44, 3, 0, 0};
    tv[4] = '{1'b1, 8'h55, 4, 1, 0};
    tv[5] = '{1'b1, 8'h66, 4, 1, 1};
    tv[6] = '{1'b0, 8'h77, 4, 1, 0};
    for (int i = 0; i < 7; i++) begin
      step(tv[i].wr, tv[i].d);
      chk("tbl_count", int'(a_cnt),  tv[i].cnt);
      chk("tbl_full",  int'(a_full), tv[i].full);
      chk("tbl_ovf",   int'(a_ovf),  tv[i].ovf);
    end
    repeat (6 * (A_F + 1)) step(1'b0, 8'($urandom));

    // Three consecutive writes produce three ordered frames and three done pulses.
    step(1'b1, 8'h2E);
    step(1'b1, 8'h3F);
    step(1'b1, 8'hDD);
    dn = 0;
    for (int i = 0; i < 3 * (A_F + 1) + 5; i++) begin
      step(1'b0, 8'($urandom));
      if (a_done) dn++;
    end
    chk("three_done", dn, 3);

    pct[0] = 5; pct[1] = 30; pct[2] = 90;
    for (int ph = 0; ph < 3; ph++)
      for (int i = 0; i < 600; i++)
        step(($urandom_range(0, 99) < pct[ph]), 8'($urandom));
    repeat (5 * (A_F + 1)) step(1'b0, 8'($urandom));

    // Reset during the fourth data bit with two words still queued.
    step(1'b1, 8'hA1);
    step(1'b1, 8'hA2);
    step(1'b1, 8'hA3);
    k = 0;
    while (k < 100 && !(m_active && (t - m_s) == 4 * A_DIV + 2)) begin
      step(1'b0, 8'h00);
      k++;
    end
    chk("reach_bit4", (k < 100) ? 1 : 0, 1);
    chk("pre_rst_count", int'(a_cnt), 2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx",    int'(a_tx),   1);
    chk("mid_rst_count", int'(a_cnt),  0);
    chk("mid_rst_busy",  int'(a_busy), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_done", int'(a_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0; lows = 0;
    for (int i = 0; i < 2 * A_F; i++) begin
      step(1'b0, 8'($urandom));
      if (a_done) dn++;
      if (!a_tx) lows++;
    end
    chk("post_rst_done", dn, 0);
    chk("post_rst_low",  lows, 0);

    // 7 data bits, 2 stop bits, CLK_DIV=4.
    @(negedge clk);
    b_wr = 1'b1; b_data = 7'h55;
    @(negedge clk);
    b_wr = 1'b0;
    dn = 0; lows = 0;
    for (int i = 0; i <= B_F; i++) begin
      @(posedge clk);
      #1;
      if (i < B_F) begin
        if (int'(b_tx) != fbit({2'b0, 7'h55}, i / B_DIV, B_DB)) begin
          chk("b_tx", int'(b_tx), fbit({2'b0, 7'h55}, i / B_DIV, B_DB));
        end
        if (!b_tx) lows++;
        if (b_done) dn++;
        if (i >= B_F - 8 && !b_tx) lows = lows + 100;
      end else begin
        chk("b_done_end", int'(b_done), 1);
        chk("b_idle_end", int'(b_tx),   1);
      end
    end
    chk("b_early_done", dn, 0);
    chk("b_low_cycles", lows, 4 * B_DIV);

    // Default parameters, 0x2E: bit centres and done timing.
    @(negedge clk);
    c_wr = 1'b1; c_data = 8'h2E;
    @(negedge clk);
    c_wr = 1'b0;
    dn = 0;
    for (int i = 0; i <= C_F; i++) begin
      @(posedge clk);
      #1;
      if (i < C_F && (i % C_DIV) == C_DIV / 2)
        chk("c_bit", int'(c_tx), fbit({1'b0, 8'h2E}, i / C_DIV, C_DB));
      if (c_done) dn++;
      if (i == C_F) chk("c_done_at_frame_end", int'(c_done), 1);
    end
    chk("c_done_count", dn, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
